// File: rtl/aimer_pkg.sv
// aimer_pkg: shared FSM state type and default parameter values for
// projectile_aimer and its per-slot sub-module.
package aimer_pkg;
  localparam int DEF_COORD_W      = 10;
  localparam int DEF_SHIFT        = 5;
  localparam int DEF_NUM_SLOTS    = 4;
  localparam int DEF_MIN_SPEED_SQ = 25;
  localparam int DEF_BOOST        = 2;
  localparam int DEF_MAX_SPEED    = 15;
  localparam int DEF_SCREEN_W     = 640;
  localparam int DEF_SCREEN_H     = 480;

  typedef enum logic [2:0] {
    IDLE, DIFF, SQX, SQY, DECIDE, ALLOC
  } aim_state_e;
endpackage

// File: rtl/projectile_aimer_if.sv
// projectile_aimer_if: fire request/response handshake plus per-slot
// projectile state.
//   master: requester side (drives frame_tick, fire_req, coordinates)
//   slave : aimer side (drives busy, fire_ack/drop, slot_* outputs)
interface projectile_aimer_if
  import aimer_pkg::*;
#(
  parameter int COORD_W   = DEF_COORD_W,
  parameter int SHIFT     = DEF_SHIFT,
  parameter int NUM_SLOTS = DEF_NUM_SLOTS
);
  localparam int VW = COORD_W - SHIFT + 1;

  logic                                frame_tick;
  logic                                fire_req;
  logic [COORD_W-1:0]                  shooter_x, shooter_y;
  logic [COORD_W-1:0]                  target_x, target_y;
  logic                                busy;
  logic                                fire_ack;
  logic                                fire_drop;
  logic [NUM_SLOTS-1:0]                slot_active;
  logic [NUM_SLOTS-1:0][COORD_W-1:0]   slot_x, slot_y;
  // two's-complement velocities
  logic [NUM_SLOTS-1:0][VW-1:0]        slot_xvel, slot_yvel;

  modport master (
    output frame_tick, fire_req, shooter_x, shooter_y, target_x, target_y,
    input  busy, fire_ack, fire_drop, slot_active, slot_x, slot_y,
           slot_xvel, slot_yvel
  );
  modport slave (
    input  frame_tick, fire_req, shooter_x, shooter_y, target_x, target_y,
    output busy, fire_ack, fire_drop, slot_active, slot_x, slot_y,
           slot_xvel, slot_yvel
  );
endinterface

// File: rtl/projectile_slot.sv
// projectile_slot: one tracked projectile. Holds position, velocity and
// active flag; moves on tick, retires when the next position leaves the
// playfield.
//   Clk/Reset_n      : clock, synchronous active-low reset
//   tick_i           : frame advance
//   load_i, ld_*_i   : allocate this slot with new position/velocity
//   active_o, x_o, y_o, xv_o, yv_o : current slot state
module projectile_slot #(
  parameter int COORD_W  = 10,
  parameter int VW       = 6,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               tick_i,
  input  logic               load_i,
  input  logic [COORD_W-1:0] ld_x_i,
  input  logic [COORD_W-1:0] ld_y_i,
  input  logic [VW-1:0]      ld_xv_i,
  input  logic [VW-1:0]      ld_yv_i,
  output logic               active_o,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic [VW-1:0]      xv_o,
  output logic [VW-1:0]      yv_o
);
  logic               active_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic [VW-1:0]      xv_q, yv_q;
  logic [COORD_W:0]   nx, ny;   // signed, one bit wider than a coordinate
  logic               out_x, out_y;

  assign nx = {1'b0, x_q} + {{(COORD_W+1-VW){xv_q[VW-1]}}, xv_q};
  assign ny = {1'b0, y_q} + {{(COORD_W+1-VW){yv_q[VW-1]}}, yv_q};
  // top bit set means the sum went negative
  assign out_x = nx[COORD_W] || (nx[COORD_W-1:0] > COORD_W'(SCREEN_W-1));
  assign out_y = ny[COORD_W] || (ny[COORD_W-1:0] > COORD_W'(SCREEN_H-1));

  // A load wins over motion so a freshly allocated slot sits still that tick.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      active_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      xv_q     <= '0;
      yv_q     <= '0;
    end else if (load_i) begin
      active_q <= 1'b1;
      x_q      <= ld_x_i;
      y_q      <= ld_y_i;
      xv_q     <= ld_xv_i;
      yv_q     <= ld_yv_i;
    end else if (tick_i && active_q) begin
      if (out_x || out_y) begin
        active_q <= 1'b0;
      end else begin
        x_q <= nx[COORD_W-1:0];
        y_q <= ny[COORD_W-1:0];
      end
    end
  end

  assign active_o = active_q;
  assign x_o      = x_q;
  assign y_o      = y_q;
  assign xv_o     = xv_q;
  assign yv_o     = yv_q;
endmodule

// File: rtl/projectile_aimer.sv
// projectile_aimer: turns a fire request (shooter, target) into a
// per-axis launch velocity through a 5-state pipeline sharing one
// squarer, then allocates the lowest free projectile slot.
//   Clk/Reset_n : clock, synchronous active-low reset
//   bus         : request/response and slot state (slave modport)
module projectile_aimer
  import aimer_pkg::*;
#(
  parameter int COORD_W      = DEF_COORD_W,
  parameter int SHIFT        = DEF_SHIFT,
  parameter int NUM_SLOTS    = DEF_NUM_SLOTS,
  parameter int MIN_SPEED_SQ = DEF_MIN_SPEED_SQ,
  parameter int BOOST        = DEF_BOOST,
  parameter int MAX_SPEED    = DEF_MAX_SPEED,
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int SCREEN_H     = DEF_SCREEN_H
) (
  input logic                Clk,
  input logic                Reset_n,
  projectile_aimer_if.slave  bus
);
  localparam int AW = COORD_W - SHIFT;   // speed magnitude width
  localparam int VW = AW + 1;            // signed velocity width
  localparam int SW = 2*AW + 1;          // ax^2 + ay^2 width

  aim_state_e         state_q;
  logic [COORD_W-1:0] sx_q, sy_q, tx_q, ty_q;
  logic               xneg_q, yneg_q;
  logic [AW-1:0]      ax_q, ay_q;
  logic [SW-1:0]      sum_q;
  logic [VW-1:0]      xv_q, yv_q;
  logic               busy_q, ack_q, drop_q;

  // DIFF stage
  logic signed [COORD_W:0] dx, dy;
  logic [COORD_W:0]        dxm, dym;
  assign dx  = $signed({1'b0, tx_q}) - $signed({1'b0, sx_q});
  assign dy  = $signed({1'b0, ty_q}) - $signed({1'b0, sy_q});
  assign dxm = dx[COORD_W] ? -dx : dx;
  assign dym = dy[COORD_W] ? -dy : dy;

  // Single squarer: ax in SQX, ay in SQY.
  logic [AW-1:0]   mul_op;
  logic [2*AW-1:0] prod;
  assign mul_op = (state_q == SQX) ? ax_q : ay_q;
  assign prod   = (2*AW)'(mul_op) * (2*AW)'(mul_op);

  // DECIDE stage: boost slow shots, clamp, reapply sign
  logic [AW:0]          bx, by;
  logic signed [VW-1:0] mx, my;
  logic [VW-1:0]        xv_d, yv_d;
  always_comb begin
    bx = {1'b0, ax_q};
    by = {1'b0, ay_q};
    if (sum_q < SW'(MIN_SPEED_SQ)) begin
      bx = bx + (AW+1)'(BOOST);
      by = by + (AW+1)'(BOOST);
    end
    if (bx > (AW+1)'(MAX_SPEED)) bx = (AW+1)'(MAX_SPEED);
    if (by > (AW+1)'(MAX_SPEED)) by = (AW+1)'(MAX_SPEED);
    mx   = $signed(bx);
    my   = $signed(by);
    xv_d = xneg_q ? -mx : mx;
    yv_d = yneg_q ? -my : my;
  end

  // Lowest free slot, judged on registered active flags so a slot
  // retiring this same cycle is not picked.
  logic [NUM_SLOTS-1:0] slot_active, load;
  logic                 found;
  always_comb begin
    found = 1'b0;
    load  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!slot_active[i] && !found) begin
        load[i] = (state_q == ALLOC);
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      sx_q <= '0; sy_q <= '0; tx_q <= '0; ty_q <= '0;
      xneg_q <= 1'b0; yneg_q <= 1'b0;
      ax_q <= '0; ay_q <= '0; sum_q <= '0;
      xv_q <= '0; yv_q <= '0;
      busy_q <= 1'b0; ack_q <= 1'b0; drop_q <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      drop_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.fire_req) begin
          sx_q    <= bus.shooter_x;
          sy_q    <= bus.shooter_y;
          tx_q    <= bus.target_x;
          ty_q    <= bus.target_y;
          busy_q  <= 1'b1;
          state_q <= DIFF;
        end
        DIFF: begin
          xneg_q  <= dx[COORD_W];
          yneg_q  <= dy[COORD_W];
          ax_q    <= AW'(dxm >> SHIFT);
          ay_q    <= AW'(dym >> SHIFT);
          state_q <= SQX;
        end
        SQX: begin
          sum_q   <= SW'(prod);
          state_q <= SQY;
        end
        SQY: begin
          sum_q   <= sum_q + SW'(prod);
          state_q <= DECIDE;
        end
        DECIDE: begin
          xv_q    <= xv_d;
          yv_q    <= yv_d;
          state_q <= ALLOC;
        end
        ALLOC: begin
          ack_q   <= found;
          drop_q  <= !found;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  logic [NUM_SLOTS-1:0][COORD_W-1:0] slot_x, slot_y;
  logic [NUM_SLOTS-1:0][VW-1:0]      slot_xv, slot_yv;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    projectile_slot #(
      .COORD_W(COORD_W), .VW(VW), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
    ) u_slot (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .tick_i   (bus.frame_tick),
      .load_i   (load[g]),
      .ld_x_i   (sx_q),
      .ld_y_i   (sy_q),
      .ld_xv_i  (xv_q),
      .ld_yv_i  (yv_q),
      .active_o (slot_active[g]),
      .x_o      (slot_x[g]),
      .y_o      (slot_y[g]),
      .xv_o     (slot_xv[g]),
      .yv_o     (slot_yv[g])
    );
  end

  assign bus.busy        = busy_q;
  assign bus.fire_ack    = ack_q;
  assign bus.fire_drop   = drop_q;
  assign bus.slot_active = slot_active;
  assign bus.slot_x      = slot_x;
  assign bus.slot_y      = slot_y;
  assign bus.slot_xvel   = slot_xv;
  assign bus.slot_yvel   = slot_yv;
endmodule

// File: tb/tb_projectile_aimer.sv
module tb_projectile_aimer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  projectile_aimer_if #(.COORD_W(10), .SHIFT(5), .NUM_SLOTS(4)) bus ();
  projectile_aimer dut (.Clk(clk), .Reset_n(rst_n), .bus(bus));

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    bit         drop;
    int         slot;
    logic [9:0] x, y;
    logic [5:0] xv, yv;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [9:0] sx, sy, tx, ty;
    bit         drop;
    logic [5:0] xv, yv;
    logic [9:0] nx, ny;   // position after one frame tick
  } vec_t;
  vec_t vecs[5];

  // Response monitor: every ack/drop must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (bus.fire_ack || bus.fire_drop)) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_drop", {31'd0, bus.fire_drop}, {31'd0, e.drop});
        if (!e.drop) begin
          chk("slot_active", {31'd0, bus.slot_active[e.slot]}, 1);
          chk("slot_x",    {22'd0, bus.slot_x[e.slot]},    {22'd0, e.x});
          chk("slot_y",    {22'd0, bus.slot_y[e.slot]},    {22'd0, e.y});
          chk("slot_xvel", {26'd0, bus.slot_xvel[e.slot]}, {26'd0, e.xv});
          chk("slot_yvel", {26'd0, bus.slot_yvel[e.slot]}, {26'd0, e.yv});
        end
      end
    end
  end

  task automatic tick();
    bus.frame_tick = 1'b1;
    @(posedge clk); #1;
    bus.frame_tick = 1'b0;
  endtask

  // Launch one request; optionally pulse frame_tick during the ALLOC cycle.
  task automatic fire(input logic [9:0] sx, sy, tx, ty, input bit tick_alloc);
    bit early = 1'b0;
    bus.shooter_x = sx; bus.shooter_y = sy;
    bus.target_x  = tx; bus.target_y  = ty;
    bus.fire_req  = 1'b1;
    @(posedge clk); #1;
    bus.fire_req = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5 && tick_alloc) bus.frame_tick = 1'b1;
      @(posedge clk); #1;
      bus.frame_tick = 1'b0;
      if (k < 5 && (bus.fire_ack || bus.fire_drop)) early = 1'b1;
    end
    chk("resp_latency", {30'd0, early, bus.fire_ack | bus.fire_drop}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    vecs[0] = '{10'd600, 10'd100, 10'd100, 10'd300, 1'b0, 6'(-15), 6'd6,    10'd585, 10'd106};
    vecs[1] = '{10'd320, 10'd240, 10'd350, 10'd250, 1'b0, 6'd2,    6'd2,    10'd322, 10'd242};
    vecs[2] = '{10'd100, 10'd400, 10'd100, 10'd100, 1'b0, 6'd0,    6'(-9),  10'd100, 10'd391};
    vecs[3] = '{10'd0,   10'd0,   10'd1023, 10'd1023, 1'b0, 6'd15, 6'd15,   10'd15,  10'd15};
    vecs[4] = '{10'd1,   10'd1,   10'd2,   10'd2,   1'b1, 6'd0,    6'd0,    10'd0,   10'd0};

    rst_n = 1'b0;
    bus.frame_tick = 1'b0; bus.fire_req = 1'b0;
    bus.shooter_x = '0; bus.shooter_y = '0; bus.target_x = '0; bus.target_y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   {31'd0, bus.busy}, 0);
    chk("rst_ack",    {31'd0, bus.fire_ack}, 0);
    chk("rst_drop",   {31'd0, bus.fire_drop}, 0);
    chk("rst_active", {28'd0, bus.slot_active}, 0);
    chk("rst_x0",     {22'd0, bus.slot_x[0]}, 0);
    chk("rst_xvel0",  {26'd0, bus.slot_xvel[0]}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill all four slots, then one more that must be dropped.
    for (int i = 0; i < 5; i++) begin
      e.drop = vecs[i].drop; e.slot = i;
      e.x = vecs[i].sx; e.y = vecs[i].sy; e.xv = vecs[i].xv; e.yv = vecs[i].yv;
      sb.push_back(e);
      fire(vecs[i].sx, vecs[i].sy, vecs[i].tx, vecs[i].ty, 1'b0);
    end
    chk("full_active", {28'd0, bus.slot_active}, 32'hF);
    chk("drop_x0_hold", {22'd0, bus.slot_x[0]}, 600);

    tick();
    for (int i = 0; i < 4; i++) begin
      chk("tick_x", {22'd0, bus.slot_x[i]}, {22'd0, vecs[i].nx});
      chk("tick_y", {22'd0, bus.slot_y[i]}, {22'd0, vecs[i].ny});
    end
    chk("tick_active", {28'd0, bus.slot_active}, 32'hF);

    // Reset while in SQY aborts the request.
    bus.shooter_x = 10'd10; bus.shooter_y = 10'd10;
    bus.target_x  = 10'd20; bus.target_y  = 10'd20;
    bus.fire_req = 1'b1;
    @(posedge clk); #1;
    bus.fire_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_in_sqy", {31'd0, bus.busy}, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy",   {31'd0, bus.busy}, 0);
    chk("abort_active", {28'd0, bus.slot_active}, 0);
    chk("abort_ack",    {31'd0, bus.fire_ack}, 0);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Slot0 retires on the same tick that allocates into slot1.
    e.drop = 1'b0; e.slot = 0; e.x = 10'd510; e.y = 10'd100; e.xv = 6'd15; e.yv = 6'd0;
    sb.push_back(e);
    fire(10'd510, 10'd100, 10'd1023, 10'd100, 1'b0);
    repeat (8) tick();
    chk("pre_retire_x0", {22'd0, bus.slot_x[0]}, 630);
    chk("pre_retire_act", {28'd0, bus.slot_active}, 1);
    e.drop = 1'b0; e.slot = 1; e.x = 10'd50; e.y = 10'd60; e.xv = 6'd2; e.yv = 6'd2;
    sb.push_back(e);
    fire(10'd50, 10'd60, 10'd50, 10'd60, 1'b1);
    chk("retire_active", {28'd0, bus.slot_active}, 32'h2);
    chk("retire_x0_hold", {22'd0, bus.slot_x[0]}, 630);
    chk("new_x1_still", {22'd0, bus.slot_x[1]}, 50);
    tick();
    chk("move_x1", {22'd0, bus.slot_x[1]}, 52);
    chk("move_y1", {22'd0, bus.slot_y[1]}, 62);
    chk("inactive_x0", {22'd0, bus.slot_x[0]}, 630);

    @(posedge clk); #1;
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
